// File: rtl/ulpi_pkg.sv
// ulpi_pkg
// Shared types and constants for the ULPI link-side transmit engine.
//  - ulpiState_e : link FSM states (boot sequencing, idle, command phases)
//  - txEntry_t   : one TX FIFO entry, {last, pid, data}
//  - ULPI_*      : ULPI command/idle byte encodings
//  - txCmdByte / regWriteCmdByte : build the command byte the link drives
package ulpi_pkg;

   typedef enum logic [3:0] {
      ST_BOOT_RST,
      ST_BOOT_WAIT,
      ST_IDLE,
      ST_TURN,
      ST_REG_CMD,
      ST_REG_DAT,
      ST_TX_CMD,
      ST_TX_DAT,
      ST_STOP,
      ST_DRAIN
   } ulpiState_e;

   localparam logic [7:0] ULPI_CMD_TX   = 8'h40;
   localparam logic [7:0] ULPI_CMD_REGW = 8'h80;
   localparam logic [7:0] ULPI_IDLE     = 8'h00;

   typedef struct packed {
      logic       last;
      logic [3:0] pid;
      logic [7:0] data;
   } txEntry_t;

   localparam int TX_ENTRY_W = $bits(txEntry_t);

   // Transmit command: the PID rides in the low nibble of the TX command.
   function automatic logic [7:0] txCmdByte(input logic [3:0] pid);
      return ULPI_CMD_TX | {4'h0, pid};
   endfunction

   // Register write command: the 6-bit address rides in the low bits.
   function automatic logic [7:0] regWriteCmdByte(input logic [5:0] addr);
      return ULPI_CMD_REGW | {2'b00, addr};
   endfunction

endpackage

// File: rtl/ulpi_tx_fifo.sv
// ulpi_tx_fifo
// Synchronous FIFO for buffered USB transmit bytes, with a packet counter
// that tracks how many complete packets (entries with the last bit set,
// stored in the MSB) are currently held.
// Ports:
//  clk_i        clock, rising edge
//  rst_ni       asynchronous active-low reset, flushes the FIFO
//  push_i       write strobe (ignored while full)
//  pushData_i   entry to write
//  pop_i        read strobe (ignored while empty)
//  headData_o   entry at the read pointer
//  nextData_o   low PEEK_W bits of the entry behind the head
//  full_o       FIFO holds DEPTH entries
//  empty_o      FIFO holds no entries
//  count_o      number of entries held
//  pktCount_o   number of complete packets held
module ulpi_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int WIDTH  = 13,
   parameter int PEEK_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         pushData_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         headData_o,
   output logic [PEEK_W-1:0]        nextData_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [$clog2(DEPTH):0]   pktCount_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W-1:0] nextPtr;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    pktCount_q;
   logic             doPush;
   logic             doPop;
   logic             pushLast;
   logic             popLast;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pktCount_o = pktCount_q;

   // Depth is a power of two, so the pointers simply wrap.
   assign nextPtr    = rdPtr_q + PTR_W'(1);
   assign headData_o = mem_q[rdPtr_q];
   assign nextData_o = mem_q[nextPtr][PEEK_W-1:0];

   assign doPush   = push_i && !full_o;
   assign doPop    = pop_i && !empty_o;
   assign pushLast = doPush && pushData_i[WIDTH-1];
   assign popLast  = doPop && headData_o[WIDTH-1];

   // Storage is not reset; the pointers and counts define what is valid.
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

   // Pointers, occupancy and packet count. A push and a pop in the same
   // cycle leave the counts unchanged.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         pktCount_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr_q <= nextPtr;
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         case ({pushLast, popLast})
            2'b10:   pktCount_q <= pktCount_q + CW'(1);
            2'b01:   pktCount_q <= pktCount_q - CW'(1);
            default: pktCount_q <= pktCount_q;
         endcase
      end
   end

endmodule

// File: rtl/ulpi_link_tx.sv
// ulpi_link_tx
// ULPI link-side transmit engine. Sequences PHY reset and boot delay, then
// serves register writes and buffered USB transmit packets on the 8-bit
// ULPI bus, handling DIR turnaround, PHY bus takeover and packet abort.
// Ports:
//  CLK_USB        60 MHz ULPI clock
//  SYS_RST_N      asynchronous active-low reset
//  DIR, NXT       PHY bus direction and throttle/accept strobe
//  STP            link stop strobe
//  USB_RST        PHY reset
//  DATA_OUT/OE    link drive value and pad output enable for ULPI data
//  SYSTEM_READY   gates the start of any new bus transaction
//  READY          boot complete
//  REG_*          register write client (REQ held until ACK pulse)
//  TX_*           packet client: FIFO write side plus DONE/ABORT pulses
module ulpi_link_tx
   import ulpi_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int RST_CYCLES  = 16,
   parameter int BOOT_CYCLES = 5000
) (
   input  logic       CLK_USB,
   input  logic       SYS_RST_N,
   input  logic       DIR,
   input  logic       NXT,
   output logic       STP,
   output logic       USB_RST,
   output logic [7:0] DATA_OUT,
   output logic       DATA_OE,
   input  logic       SYSTEM_READY,
   output logic       READY,
   input  logic       REG_REQ,
   input  logic [5:0] REG_ADDR,
   input  logic [7:0] REG_DATA,
   output logic       REG_ACK,
   input  logic       TX_VALID,
   input  logic [7:0] TX_DATA,
   input  logic [3:0] TX_PID,
   input  logic       TX_LAST,
   output logic       TX_READY,
   output logic       TX_DONE,
   output logic       TX_ABORT
);

   localparam int BOOT_MAX   = (RST_CYCLES > BOOT_CYCLES) ? RST_CYCLES : BOOT_CYCLES;
   localparam int CNT_W      = $clog2(BOOT_MAX + 1);
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

   ulpiState_e             state_q;
   logic [CNT_W-1:0]       bootCnt_q;
   logic                   dirPrev_q;
   logic                   stp_q;
   logic                   usbRst_q;
   logic [7:0]             dataOut_q;
   logic                   dataOe_q;
   logic                   ready_q;
   logic                   regAck_q;
   logic                   txDone_q;
   logic                   txAbort_q;

   txEntry_t               headEntry;
   logic [7:0]             nextByte;
   txEntry_t               pushEntry;
   logic                   fifoPush;
   logic                   fifoPop;
   logic                   fifoFull;
   logic                   fifoEmpty;
   logic [FIFO_CNT_W-1:0]  fifoCount;
   logic [FIFO_CNT_W-1:0]  pktCount;

   assign STP      = stp_q;
   assign USB_RST  = usbRst_q;
   assign DATA_OUT = dataOut_q;
   assign DATA_OE  = dataOe_q;
   assign READY    = ready_q;
   assign REG_ACK  = regAck_q;
   assign TX_DONE  = txDone_q;
   assign TX_ABORT = txAbort_q;

   assign TX_READY  = (fifoCount != FIFO_CNT_W'(FIFO_DEPTH));
   assign pushEntry = '{last: TX_LAST, pid: TX_PID, data: TX_DATA};
   assign fifoPush  = TX_VALID && !fifoFull;

   // Pop when the PHY accepts a data byte, or unconditionally while
   // draining an aborted packet. While DIR is high NXT belongs to the PHY's
   // receive side, so it never pops in TX_DAT.
   assign fifoPop = ((state_q == ST_TX_DAT) && !DIR && NXT) ||
                    ((state_q == ST_DRAIN) && !fifoEmpty);

   ulpi_tx_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .WIDTH  (TX_ENTRY_W),
      .PEEK_W (8)
   ) u_fifo (
      .clk_i      (CLK_USB),
      .rst_ni     (SYS_RST_N),
      .push_i     (fifoPush),
      .pushData_i (pushEntry),
      .pop_i      (fifoPop),
      .headData_o (headEntry),
      .nextData_o (nextByte),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .count_o    (fifoCount),
      .pktCount_o (pktCount)
   );

   // Link FSM with registered outputs. Pulse outputs default low each cycle
   // and are raised only on the edge that enters the state they belong to.
   // DATA_OUT is loaded one cycle ahead so the bus shows the next byte in
   // the cycle after NXT was sampled high.
   always_ff @(posedge CLK_USB or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         state_q   <= ST_BOOT_RST;
         bootCnt_q <= '0;
         dirPrev_q <= 1'b0;
         stp_q     <= 1'b0;
         usbRst_q  <= 1'b1;
         dataOut_q <= ULPI_IDLE;
         dataOe_q  <= 1'b0;
         ready_q   <= 1'b0;
         regAck_q  <= 1'b0;
         txDone_q  <= 1'b0;
         txAbort_q <= 1'b0;
      end else begin
         dirPrev_q <= DIR;
         stp_q     <= 1'b0;
         regAck_q  <= 1'b0;
         txDone_q  <= 1'b0;
         txAbort_q <= 1'b0;
         case (state_q)
            ST_BOOT_RST: begin
               if (bootCnt_q == CNT_W'(RST_CYCLES - 1)) begin
                  usbRst_q  <= 1'b0;
                  bootCnt_q <= '0;
                  state_q   <= ST_BOOT_WAIT;
               end else begin
                  bootCnt_q <= bootCnt_q + CNT_W'(1);
               end
            end
            ST_BOOT_WAIT: begin
               if (bootCnt_q == CNT_W'(BOOT_CYCLES - 1)) begin
                  ready_q   <= 1'b1;
                  dataOe_q  <= !DIR;
                  bootCnt_q <= '0;
                  state_q   <= ST_IDLE;
               end else begin
                  bootCnt_q <= bootCnt_q + CNT_W'(1);
               end
            end
            ST_IDLE: begin
               dataOut_q <= ULPI_IDLE;
               if (DIR) begin
                  dataOe_q <= 1'b0;
               end else if (dirPrev_q) begin
                  dataOe_q <= 1'b0;
                  state_q  <= ST_TURN;
               end else begin
                  dataOe_q <= 1'b1;
                  if (SYSTEM_READY && REG_REQ) begin
                     dataOut_q <= regWriteCmdByte(REG_ADDR);
                     state_q   <= ST_REG_CMD;
                  end else if (SYSTEM_READY && (pktCount != '0)) begin
                     dataOut_q <= txCmdByte(headEntry.pid);
                     state_q   <= ST_TX_CMD;
                  end
               end
            end
            ST_TURN: begin
               dataOut_q <= ULPI_IDLE;
               dataOe_q  <= !DIR;
               state_q   <= ST_IDLE;
            end
            ST_REG_CMD: begin
               if (DIR) begin
                  dataOe_q  <= 1'b0;
                  dataOut_q <= ULPI_IDLE;
                  state_q   <= ST_IDLE;
               end else if (NXT) begin
                  dataOut_q <= REG_DATA;
                  state_q   <= ST_REG_DAT;
               end
            end
            ST_REG_DAT: begin
               if (DIR) begin
                  dataOe_q  <= 1'b0;
                  dataOut_q <= ULPI_IDLE;
                  state_q   <= ST_IDLE;
               end else if (NXT) begin
                  stp_q     <= 1'b1;
                  regAck_q  <= 1'b1;
                  dataOut_q <= ULPI_IDLE;
                  state_q   <= ST_STOP;
               end
            end
            ST_TX_CMD: begin
               if (DIR) begin
                  dataOe_q  <= 1'b0;
                  dataOut_q <= ULPI_IDLE;
                  state_q   <= ST_IDLE;
               end else if (NXT) begin
                  dataOut_q <= headEntry.data;
                  state_q   <= ST_TX_DAT;
               end
            end
            ST_TX_DAT: begin
               if (DIR) begin
                  txAbort_q <= 1'b1;
                  dataOe_q  <= 1'b0;
                  dataOut_q <= ULPI_IDLE;
                  state_q   <= ST_DRAIN;
               end else if (NXT) begin
                  if (headEntry.last) begin
                     stp_q     <= 1'b1;
                     txDone_q  <= 1'b1;
                     dataOut_q <= ULPI_IDLE;
                     state_q   <= ST_STOP;
                  end else begin
                     dataOut_q <= nextByte;
                  end
               end
            end
            ST_STOP: begin
               dataOut_q <= ULPI_IDLE;
               dataOe_q  <= !DIR;
               state_q   <= ST_IDLE;
            end
            ST_DRAIN: begin
               dataOe_q  <= 1'b0;
               dataOut_q <= ULPI_IDLE;
               if (fifoEmpty || headEntry.last) begin
                  // If the PHY already released the bus while draining, the
                  // falling edge was missed by IDLE, so turn around here.
                  state_q <= DIR ? ST_IDLE : ST_TURN;
               end
            end
            default: begin
               state_q <= ST_BOOT_RST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ulpi_link_tx.sv
// tb_ulpi_link_tx
// Directed testbench for ulpi_link_tx: boot sequencing, register write,
// packet transmit with NXT stalls, DIR takeover (register retry and packet
// abort), FIFO full handling with register priority, and reset mid-packet.
module tb_ulpi_link_tx;

   logic       clkUsb = 1'b0;
   logic       sysRstN;
   logic       dir;
   logic       nxt;
   logic       stp;
   logic       usbRst;
   logic [7:0] dataOut;
   logic       dataOe;
   logic       systemReady;
   logic       ready;
   logic       regReq;
   logic [5:0] regAddr;
   logic [7:0] regData;
   logic       regAck;
   logic       txValid;
   logic [7:0] txData;
   logic [3:0] txPid;
   logic       txLast;
   logic       txReady;
   logic       txDone;
   logic       txAbort;

   int testsRun    = 0;
   int testsFailed = 0;

   ulpi_link_tx #(
      .FIFO_DEPTH  (16),
      .RST_CYCLES  (16),
      .BOOT_CYCLES (5000)
   ) dut (
      .CLK_USB      (clkUsb),
      .SYS_RST_N    (sysRstN),
      .DIR          (dir),
      .NXT          (nxt),
      .STP          (stp),
      .USB_RST      (usbRst),
      .DATA_OUT     (dataOut),
      .DATA_OE      (dataOe),
      .SYSTEM_READY (systemReady),
      .READY        (ready),
      .REG_REQ      (regReq),
      .REG_ADDR     (regAddr),
      .REG_DATA     (regData),
      .REG_ACK      (regAck),
      .TX_VALID     (txValid),
      .TX_DATA      (txData),
      .TX_PID       (txPid),
      .TX_LAST      (txLast),
      .TX_READY     (txReady),
      .TX_DONE      (txDone),
      .TX_ABORT     (txAbort)
   );

   // 60 MHz-ish clock; exact period is irrelevant to the design.
   always #5 clkUsb = ~clkUsb;

   // Advance one clock and land 1 time unit after the rising edge, where
   // outputs are sampled and new inputs are driven.
   task automatic tick();
      @(posedge clkUsb);
      #1;
   endtask

   task automatic pushByte(input logic [7:0] d, input logic [3:0] p, input logic l);
      txValid = 1'b1;
      txData  = d;
      txPid   = p;
      txLast  = l;
      tick();
      txValid = 1'b0;
      txLast  = 1'b0;
   endtask

   // All outputs at their reset values while SYS_RST_N is held low.
   task automatic test_reset();
      sysRstN = 1'b0;
      repeat (3) tick();
      testsRun++;
      if ({usbRst, stp, dataOut, dataOe, ready, regAck, txDone, txAbort, txReady} !==
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL reset_values: got %0h expected %0h",
                  {usbRst, stp, dataOut, dataOe, ready, regAck, txDone, txAbort, txReady},
                  {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      end
   endtask

   // USB_RST width, boot wait length, DATA_OE quiet until READY.
   task automatic test_boot();
      int n;
      bit oeEarly;
      oeEarly = 1'b0;
      sysRstN = 1'b1;
      n = 0;
      while (usbRst === 1'b1 && n < 100) begin
         tick();
         n++;
         if (dataOe !== 1'b0) oeEarly = 1'b1;
      end
      testsRun++;
      if (n !== 16) begin
         testsFailed++;
         $display("[TB] FAIL usb_rst_cycles: got %0d expected %0d", n, 16);
      end
      n = 0;
      while (ready !== 1'b1 && n < 6000) begin
         tick();
         n++;
         if (ready !== 1'b1 && dataOe !== 1'b0) oeEarly = 1'b1;
      end
      testsRun++;
      if (n !== 5000) begin
         testsFailed++;
         $display("[TB] FAIL boot_wait_cycles: got %0d expected %0d", n, 5000);
      end
      testsRun++;
      if (oeEarly !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL oe_during_boot: got %0d expected %0d", oeEarly, 0);
      end
      testsRun++;
      if (dataOe !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL oe_after_boot: got %0d expected %0d", dataOe, 1);
      end
   endtask

   // Register write 0x04 <- 0x45 with one NXT stall on the command byte.
   task automatic test_reg_write();
      regAddr = 6'h04;
      regData = 8'h45;
      regReq  = 1'b1;
      nxt     = 1'b0;
      tick();
      testsRun++;
      if ({dataOe, stp, dataOut} !== {1'b1, 1'b0, 8'h84}) begin
         testsFailed++;
         $display("[TB] FAIL reg_cmd: got %0h expected %0h", {dataOe, stp, dataOut}, {1'b1, 1'b0, 8'h84});
      end
      tick();
      testsRun++;
      if (dataOut !== 8'h84) begin
         testsFailed++;
         $display("[TB] FAIL reg_cmd_stall: got %0h expected %0h", dataOut, 8'h84);
      end
      nxt = 1'b1;
      tick();
      testsRun++;
      if ({stp, dataOut} !== {1'b0, 8'h45}) begin
         testsFailed++;
         $display("[TB] FAIL reg_dat: got %0h expected %0h", {stp, dataOut}, {1'b0, 8'h45});
      end
      tick();
      testsRun++;
      if ({stp, regAck, dataOut} !== {1'b1, 1'b1, 8'h00}) begin
         testsFailed++;
         $display("[TB] FAIL reg_stop: got %0h expected %0h", {stp, regAck, dataOut}, {1'b1, 1'b1, 8'h00});
      end
      nxt    = 1'b0;
      regReq = 1'b0;
      tick();
      testsRun++;
      if ({stp, regAck, dataOut, dataOe} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL reg_after_stop: got %0h expected %0h",
                  {stp, regAck, dataOut, dataOe}, {1'b0, 1'b0, 8'h00, 1'b1});
      end
   endtask

   // DIR takeover during REG_CMD: drop OE, turn around, retry the write.
   task automatic test_reg_dir_retry();
      regAddr = 6'h15;
      regData = 8'h99;
      regReq  = 1'b1;
      tick();
      testsRun++;
      if (dataOut !== 8'h95) begin
         testsFailed++;
         $display("[TB] FAIL retry_first_cmd: got %0h expected %0h", dataOut, 8'h95);
      end
      dir = 1'b1;
      tick();
      testsRun++;
      if ({dataOe, regAck} !== {1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL retry_oe_drop: got %0h expected %0h", {dataOe, regAck}, 2'b00);
      end
      tick();
      dir = 1'b0;
      tick();
      testsRun++;
      if (dataOe !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL retry_turn: got %0h expected %0h", dataOe, 1'b0);
      end
      tick();
      testsRun++;
      if ({dataOe, dataOut} !== {1'b1, 8'h00}) begin
         testsFailed++;
         $display("[TB] FAIL retry_idle: got %0h expected %0h", {dataOe, dataOut}, {1'b1, 8'h00});
      end
      tick();
      testsRun++;
      if (dataOut !== 8'h95) begin
         testsFailed++;
         $display("[TB] FAIL retry_second_cmd: got %0h expected %0h", dataOut, 8'h95);
      end
      nxt = 1'b1;
      tick();
      tick();
      testsRun++;
      if ({stp, regAck} !== {1'b1, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL retry_ack: got %0h expected %0h", {stp, regAck}, 2'b11);
      end
      nxt    = 1'b0;
      regReq = 1'b0;
      tick();
   endtask

   // Three-byte packet with NXT stalls, STP/TX_DONE, FIFO left empty.
   task automatic test_packet();
      bit sawTx;
      logic [7:0] expBytes [3];
      logic       nxtPat [8];
      logic [8:0] expOut [8];
      expBytes = '{8'hA5, 8'h5A, 8'hC3};
      pushByte(expBytes[0], 4'h1, 1'b0);
      pushByte(expBytes[1], 4'h1, 1'b0);
      pushByte(expBytes[2], 4'h1, 1'b1);
      tick();
      testsRun++;
      if ({dataOe, dataOut} !== {1'b1, 8'h41}) begin
         testsFailed++;
         $display("[TB] FAIL pkt_cmd: got %0h expected %0h", {dataOe, dataOut}, {1'b1, 8'h41});
      end
      // NXT pattern and the resulting {STP, DATA_OUT} one cycle later.
      nxtPat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      expOut = '{{1'b0, 8'h41}, {1'b0, 8'hA5}, {1'b0, 8'hA5}, {1'b0, 8'h5A},
                 {1'b0, 8'hC3}, {1'b0, 8'hC3}, {1'b1, 8'h00}, {1'b0, 8'h00}};
      for (int i = 0; i < 8; i++) begin
         nxt = nxtPat[i];
         tick();
         testsRun++;
         if ({stp, dataOut} !== expOut[i]) begin
            testsFailed++;
            $display("[TB] FAIL pkt_step%0d: got %0h expected %0h", i, {stp, dataOut}, expOut[i]);
         end
         if (i == 6) begin
            testsRun++;
            if (txDone !== 1'b1) begin
               testsFailed++;
               $display("[TB] FAIL pkt_done: got %0h expected %0h", txDone, 1'b1);
            end
         end
      end
      sawTx = 1'b0;
      repeat (4) begin
         tick();
         if (dataOut !== 8'h00 || stp !== 1'b0 || txDone !== 1'b0) sawTx = 1'b1;
      end
      testsRun++;
      if (sawTx !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL pkt_fifo_empty: got %0d expected %0d", sawTx, 0);
      end
   endtask

   // DIR rises after the first data byte: abort, drain, turnaround, idle.
   task automatic test_dir_abort();
      bit sawTx;
      pushByte(8'hA5, 4'h1, 1'b0);
      pushByte(8'h5A, 4'h1, 1'b0);
      pushByte(8'hC3, 4'h1, 1'b1);
      tick();
      nxt = 1'b1;
      tick();
      tick();
      testsRun++;
      if (dataOut !== 8'h5A) begin
         testsFailed++;
         $display("[TB] FAIL abort_second_byte: got %0h expected %0h", dataOut, 8'h5A);
      end
      nxt = 1'b0;
      dir = 1'b1;
      tick();
      testsRun++;
      if ({txAbort, dataOe, stp, txDone} !== 4'b1000) begin
         testsFailed++;
         $display("[TB] FAIL abort_pulse: got %0h expected %0h", {txAbort, dataOe, stp, txDone}, 4'b1000);
      end
      tick();
      testsRun++;
      if ({txAbort, dataOe} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL abort_one_cycle: got %0h expected %0h", {txAbort, dataOe}, 2'b00);
      end
      repeat (3) tick();
      dir = 1'b0;
      tick();
      testsRun++;
      if (dataOe !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL abort_turn: got %0h expected %0h", dataOe, 1'b0);
      end
      tick();
      testsRun++;
      if ({dataOe, dataOut} !== {1'b1, 8'h00}) begin
         testsFailed++;
         $display("[TB] FAIL abort_idle: got %0h expected %0h", {dataOe, dataOut}, {1'b1, 8'h00});
      end
      sawTx = 1'b0;
      repeat (4) begin
         tick();
         if (dataOut !== 8'h00 || stp !== 1'b0) sawTx = 1'b1;
      end
      testsRun++;
      if (sawTx !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL abort_drained: got %0d expected %0d", sawTx, 0);
      end
   endtask

   // Fill the FIFO, drop a 17th push, then register write wins over TX.
   task automatic test_full_priority();
      bit sawTx;
      systemReady = 1'b0;
      for (int i = 0; i < 16; i++) begin
         pushByte(8'h10 + 8'(i), 4'h2, (i == 15));
      end
      testsRun++;
      if (txReady !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL full_tx_ready: got %0h expected %0h", txReady, 1'b0);
      end
      pushByte(8'hEE, 4'h7, 1'b1);
      regAddr     = 6'h0A;
      regData     = 8'h3C;
      regReq      = 1'b1;
      systemReady = 1'b1;
      tick();
      testsRun++;
      if (dataOut !== 8'h8A) begin
         testsFailed++;
         $display("[TB] FAIL priority_reg_first: got %0h expected %0h", dataOut, 8'h8A);
      end
      nxt = 1'b1;
      tick();
      tick();
      testsRun++;
      if ({stp, regAck} !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL priority_reg_ack: got %0h expected %0h", {stp, regAck}, 2'b11);
      end
      nxt    = 1'b0;
      regReq = 1'b0;
      tick();
      tick();
      testsRun++;
      if (dataOut !== 8'h42) begin
         testsFailed++;
         $display("[TB] FAIL full_pkt_cmd: got %0h expected %0h", dataOut, 8'h42);
      end
      nxt = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         testsRun++;
         if (dataOut !== 8'h10 + 8'(i)) begin
            testsFailed++;
            $display("[TB] FAIL full_byte%0d: got %0h expected %0h", i, dataOut, 8'h10 + 8'(i));
         end
      end
      tick();
      testsRun++;
      if ({stp, txDone} !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL full_pkt_done: got %0h expected %0h", {stp, txDone}, 2'b11);
      end
      nxt   = 1'b0;
      sawTx = 1'b0;
      repeat (4) begin
         tick();
         if (dataOut !== 8'h00 || stp !== 1'b0) sawTx = 1'b1;
      end
      testsRun++;
      if ({sawTx, txReady} !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL full_dropped_17th: got %0h expected %0h", {sawTx, txReady}, 2'b01);
      end
   endtask

   // Asynchronous reset in TX_DAT forces reset values at once and flushes.
   task automatic test_reset_mid_packet();
      int n;
      bit sawTx;
      pushByte(8'h11, 4'h3, 1'b0);
      pushByte(8'h22, 4'h3, 1'b0);
      pushByte(8'h33, 4'h3, 1'b1);
      tick();
      nxt = 1'b1;
      tick();
      tick();
      testsRun++;
      if (dataOut !== 8'h22) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_byte: got %0h expected %0h", dataOut, 8'h22);
      end
      #2;
      sysRstN = 1'b0;
      #1;
      testsRun++;
      if ({stp, dataOe, usbRst, dataOut, ready, txReady} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL rst_mid_values: got %0h expected %0h",
                  {stp, dataOe, usbRst, dataOut, ready, txReady}, {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1});
      end
      nxt = 1'b0;
      tick();
      sysRstN = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 6000) begin
         tick();
         n++;
      end
      testsRun++;
      if (n !== 5016) begin
         testsFailed++;
         $display("[TB] FAIL rst_reboot_cycles: got %0d expected %0d", n, 5016);
      end
      sawTx = 1'b0;
      repeat (5) begin
         tick();
         if (dataOut !== 8'h00 || stp !== 1'b0) sawTx = 1'b1;
      end
      testsRun++;
      if ({sawTx, dataOe} !== 2'b01) begin
         testsFailed++;
         $display("[TB] FAIL rst_fifo_flushed: got %0h expected %0h", {sawTx, dataOe}, 2'b01);
      end
   endtask

   initial begin
      sysRstN     = 1'b0;
      dir         = 1'b0;
      nxt         = 1'b0;
      systemReady = 1'b1;
      regReq      = 1'b0;
      regAddr     = 6'h00;
      regData     = 8'h00;
      txValid     = 1'b0;
      txData      = 8'h00;
      txPid       = 4'h0;
      txLast      = 1'b0;

      test_reset();
      test_boot();
      test_reg_write();
      test_reg_dir_retry();
      test_packet();
      test_dir_abort();
      test_full_priority();
      test_reset_mid_packet();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
